// File: rtl/dm_pkg.sv
// Shared DMCtrl encodings and store byte-mask helper
// for the data memory slice.
package dm_pkg;

  localparam logic [2:0] DM_LB  = 3'b000;
  localparam logic [2:0] DM_LH  = 3'b001;
  localparam logic [2:0] DM_LW  = 3'b010;
  localparam logic [2:0] DM_SW  = 3'b011;
  localparam logic [2:0] DM_LBU = 3'b100;
  localparam logic [2:0] DM_LHU = 3'b101;
  localparam logic [2:0] DM_SB  = 3'b110;
  localparam logic [2:0] DM_SH  = 3'b111;

  // Bytes touched by a store, lane k = byte A+k.
  function automatic logic [3:0] dm_wr_mask(
    input logic [2:0] ctrl
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      ctrl == DM_SB: m = 4'b0001;
      ctrl == DM_SH: m = 4'b0011;
      ctrl == DM_SW: m = 4'b1111;
      default:       m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_memory_load_ext.sv
// Selects and sign/zero-extends the load result
// from the four little-endian bytes at A..A+3.
module data_memory_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  ctrl,
  output logic [31:0] data_rd
);

  always_comb begin
    data_rd = '0;
    unique case (1'b1)
      ctrl == DM_LB:
        data_rd = {{24{word[7]}}, word[7:0]};
      ctrl == DM_LBU:
        data_rd = {24'h0, word[7:0]};
      ctrl == DM_LH:
        data_rd = {{16{word[15]}}, word[15:0]};
      ctrl == DM_LHU:
        data_rd = {16'h0, word[15:0]};
      ctrl == DM_LW:
        data_rd = word;
      default:
        data_rd = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory:
// synchronous writes, combinational reads.
module data_memory
  import dm_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Address,
  input  logic [31:0] DataWr,
  input  logic        DMWr,
  input  logic [2:0]  DMCtrl,
  output logic [31:0] DataRd
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [7:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] idx [4];
  logic [31:0]           rd_word;
  logic [3:0]            wr_mask;
  logic                  unused_hi;

  // Upper address bits alias onto the same storage.
  assign base      = Address[ADDR_WIDTH-1:0];
  assign unused_hi = ^Address[31:ADDR_WIDTH];

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign idx[k] = base + ADDR_WIDTH'(k);
    assign rd_word[8*k +: 8] = mem[idx[k]];
  end

  assign wr_mask = DMWr ? dm_wr_mask(DMCtrl) : 4'b0000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 8'h00;
    end else begin
      for (int k = 0; k < 4; k++)
        if (wr_mask[k])
          mem[idx[k]] <= DataWr[8*k +: 8];
    end
  end

  data_memory_load_ext u_load_ext (
    .word    (rd_word),
    .ctrl    (DMCtrl),
    .data_rd (DataRd)
  );

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory with a
// byte-array reference model and random traffic.
module tb_data_memory;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] SW  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b110;
  localparam logic [2:0] SH  = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] DataWr = '0;
  logic        DMWr = 1'b0;
  logic [2:0]  DMCtrl = LW;
  logic [31:0] DataRd;

  int checks = 0;
  int failures = 0;

  logic [7:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  data_memory #(.ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Address (Address),
    .DataWr  (DataWr),
    .DMWr    (DMWr),
    .DMCtrl  (DMCtrl),
    .DataRd  (DataRd)
  );

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] exp;
    string       name;
  } rd_chk_t;

  function automatic int width_of(input logic [2:0] c);
    if (c == LB || c == LBU || c == SB) return 1;
    if (c == LH || c == LHU || c == SH) return 2;
    return 4;
  endfunction

  function automatic bit is_store(input logic [2:0] c);
    return c == SW || c == SB || c == SH;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endfunction

  function automatic logic [31:0] model_read(
    input logic [2:0] c, input logic [31:0] a);
    longint v;
    int     w;
    int     b;
    if (is_store(c)) return 32'h0;
    w = width_of(c);
    b = int'(a % DEPTH);
    v = 0;
    for (int k = 0; k < w; k++)
      v += longint'(ref_mem[(b + k) % DEPTH]) << (8 * k);
    if ((c == LB || c == LH) && v >= (longint'(1) << (8 * w - 1)))
      v -= longint'(1) << (8 * w);
    return 32'(v);
  endfunction

  function automatic void model_write(
    input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    int b;
    if (!is_store(c)) return;
    b = int'(a % DEPTH);
    for (int k = 0; k < width_of(c); k++)
      ref_mem[(b + k) % DEPTH] = 8'((d >> (8 * k)) & 32'hFF);
  endfunction

  task automatic do_write(
    input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    DMCtrl = c; Address = a; DataWr = d; DMWr = 1'b1;
    @(posedge clk);
    model_write(c, a, d);
    #1;
    DMWr = 1'b0;
  endtask

  task automatic set_read(input logic [2:0] c, input logic [31:0] a);
    DMWr = 1'b0; DMCtrl = c; Address = a;
    #1;
  endtask

  task automatic test_reset();
    rd_chk_t t [4];
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    t[0] = '{LW,  32'h000, 32'h0, "reset_lw0"};
    t[1] = '{LB,  32'h155, 32'h0, "reset_lb155"};
    t[2] = '{LW,  32'h3FC, 32'h0, "reset_lw3fc"};
    t[3] = '{LHU, 32'h200, 32'h0, "reset_lhu200"};
    foreach (t[i]) begin
      set_read(t[i].ctrl, t[i].addr);
      checks++;
      if (DataRd !== t[i].exp) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", t[i].name, DataRd, t[i].exp);
      end
    end
  endtask

  task automatic test_word();
    do_write(SW, 32'h000, 32'hDEADBEEF);
    set_read(LW, 32'h000);
    checks++;
    if (DataRd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL sw_lw got=%h exp=%h", DataRd, 32'hDEADBEEF);
    end
  endtask

  task automatic test_byte_half();
    rd_chk_t t [7];
    do_write(SB, 32'h004, 32'h000000AB);
    do_write(SB, 32'h005, 32'h123456CD);
    do_write(SB, 32'h008, 32'h000000FF);
    do_write(SH, 32'h00C, 32'h00001234);
    do_write(SH, 32'h00E, 32'hABCD5678);
    do_write(SH, 32'h010, 32'h0000FFFF);
    t[0] = '{LBU, 32'h004, 32'h000000AB, "lbu_004"};
    t[1] = '{LBU, 32'h005, 32'h000000CD, "lbu_005"};
    t[2] = '{LB,  32'h008, 32'hFFFFFFFF, "lb_008"};
    t[3] = '{LHU, 32'h00C, 32'h00001234, "lhu_00c"};
    t[4] = '{LHU, 32'h00E, 32'h00005678, "lhu_00e"};
    t[5] = '{LW,  32'h00C, 32'h56781234, "lw_00c"};
    t[6] = '{LH,  32'h010, 32'hFFFFFFFF, "lh_010"};
    foreach (t[i]) begin
      set_read(t[i].ctrl, t[i].addr);
      checks++;
      if (DataRd !== t[i].exp) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", t[i].name, DataRd, t[i].exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int k = 0; k < 4; k++)
      do_write(SB, 32'h014 + k, {24'h0, bytes[k]});
    set_read(LW, 32'h014);
    checks++;
    if (DataRd !== 32'hDDCCBBAA) begin
      failures++;
      $display("FAIL b2b_lw got=%h exp=%h", DataRd, 32'hDDCCBBAA);
    end
  endtask

  task automatic test_load_no_write();
    do_write(LW, 32'h014, 32'h11111111);
    set_read(LW, 32'h014);
    checks++;
    if (DataRd !== 32'hDDCCBBAA) begin
      failures++;
      $display("FAIL load_we got=%h exp=%h", DataRd, 32'hDDCCBBAA);
    end
  endtask

  task automatic test_reset_priority();
    DMCtrl = SW; Address = 32'h014; DataWr = 32'h99887766;
    DMWr = 1'b1; rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; DMWr = 1'b0;
    model_clear();
    set_read(LW, 32'h014);
    checks++;
    if (DataRd !== 32'h0) begin
      failures++;
      $display("FAIL rst_prio got=%h exp=%h", DataRd, 32'h0);
    end
  endtask

  task automatic test_wrap();
    rd_chk_t t [4];
    do_write(SW, 32'h3FE, 32'h44332211);
    t[0] = '{LW,  32'h3FE, 32'h44332211, "wrap_lw"};
    t[1] = '{LBU, 32'h000, 32'h00000033, "wrap_lbu0"};
    t[2] = '{LBU, 32'h400, 32'h00000033, "alias_lbu400"};
    t[3] = '{SW,  32'h3FE, 32'h00000000, "store_rd0"};
    foreach (t[i]) begin
      set_read(t[i].ctrl, t[i].addr);
      checks++;
      if (DataRd !== t[i].exp) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", t[i].name, DataRd, t[i].exp);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    bit          we;
    for (int n = 0; n < 400; n++) begin
      c  = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? $urandom()
                                       : 32'($urandom_range(0, 47));
      if ($urandom_range(0, 7) == 0) a = 32'h3FC + 32'($urandom_range(0, 3));
      d  = $urandom();
      we = 1'($urandom_range(0, 1));
      DMCtrl = c; Address = a; DataWr = d; DMWr = we;
      #1;
      exp = model_read(c, a);
      checks++;
      if (DataRd !== exp) begin
        failures++;
        $display("FAIL rnd_pre n=%0d ctrl=%b addr=%h got=%h exp=%h",
                 n, c, a, DataRd, exp);
      end
      @(posedge clk);
      if (we) model_write(c, a, d);
      #1;
      DMWr = 1'b0;
      c = LW;
      set_read(c, a);
      exp = model_read(c, a);
      checks++;
      if (DataRd !== exp) begin
        failures++;
        $display("FAIL rnd_post n=%0d addr=%h got=%h exp=%h",
                 n, a, DataRd, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_back_to_back();
    test_load_no_write();
    test_reset_priority();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
